// File: rtl/matrix_pkg.sv
// Shared types, op codes and element helpers for the 4x4 int8 matrix unit.
// Build option: define MATRIX_SAT_EN to saturate add/sub/multiply results
// to [-128, 127]; otherwise results wrap to the low 8 bits.
package matrix_pkg;

  localparam int unsigned DIM = 4;
  localparam int unsigned EW  = 8;
  localparam int unsigned RW  = DIM * EW;
  localparam int unsigned MW  = DIM * RW;
  // Wide enough for the exact sum of four int8 x int8 products.
  localparam int unsigned AW  = 18;

  localparam logic [2:0] MX_MADD   = 3'b000;
  localparam logic [2:0] MX_MSUB   = 3'b001;
  localparam logic [2:0] MX_MMUL   = 3'b010;
  localparam logic [2:0] MX_MTRANS = 3'b011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mx_state_e;

  // Sign-extend one element to accumulator width.
  function automatic logic signed [AW-1:0] mx_sext(input logic [EW-1:0] i_x);
    return {{(AW-EW){i_x[EW-1]}}, i_x};
  endfunction

  // Narrow an exact result back to one element.
  function automatic logic [EW-1:0] mx_narrow(input logic signed [AW-1:0] i_v);
    logic [EW-1:0] v_res;
`ifdef MATRIX_SAT_EN
    if (i_v > 18'sd127) begin
      v_res = 8'h7F;
    end else if (i_v < -18'sd128) begin
      v_res = 8'h80;
    end else begin
      v_res = EW'(i_v);
    end
`else
    v_res = EW'(i_v);
`endif
    return v_res;
  endfunction

endpackage

// File: rtl/mx_row_mac.sv
// One output row of C = A x B: a 32-bit A row against the full B matrix.
module mx_row_mac
  import matrix_pkg::*;
(
  input  logic [RW-1:0] i_a_row,
  input  logic [MW-1:0] i_b,
  output logic [RW-1:0] o_row_c
);

  // Per column: exact dot product of the A row with B column c, then narrow.
  always_comb begin
    logic signed [AW-1:0] v_acc;
    logic signed [AW-1:0] v_a;
    logic signed [AW-1:0] v_b;
    o_row_c = '0;
    v_acc   = '0;
    v_a     = '0;
    v_b     = '0;
    for (int c = 0; c < DIM; c++) begin
      v_acc = '0;
      for (int k = 0; k < DIM; k++) begin
        v_a   = mx_sext(i_a_row[k*EW +: EW]);
        v_b   = mx_sext(i_b[(k*DIM + c)*EW +: EW]);
        v_acc = v_acc + v_a * v_b;
      end
      o_row_c[c*EW +: EW] = mx_narrow(v_acc);
    end
  end

endmodule

// File: rtl/ex_matrix_unit.sv
// EX-stage 4x4 int8 matrix unit: add/sub/transpose in one busy cycle,
// multiply one row per busy cycle. Stalls the front of the pipe while busy.
// Build option: MATRIX_SAT_EN selects saturating narrowing (see matrix_pkg).
module ex_matrix_unit
  import matrix_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          mx_start,
  input  logic [2:0]    mx_func3,
  input  logic [MW-1:0] mx_a,
  input  logic [MW-1:0] mx_b,
  input  logic          mx_flush,
  output logic [MW-1:0] ex_matrix_o,
  output logic          mx_done,
  output logic          mx_busy,
  output logic          mx_err,
  output logic          mx_stall
);

  mx_state_e          r_state;
  mx_state_e          w_nstate;
  logic [MW-1:0]      r_a;
  logic [MW-1:0]      r_b;
  logic [2:0]         r_op;
  logic [1:0]         r_row;
  logic [MW-RW-1:0]   r_buf;
  logic [MW-1:0]      w_result;
  logic [RW-1:0]      w_a_row;
  logic [RW-1:0]      w_mac_row;
  logic               w_accept;
  logic               w_complete;
  logic               w_mmul_step;
  logic               w_illegal;

  // Stall must cover the start cycle itself, before busy registers.
  assign mx_stall  = mx_busy | (mx_start & ~mx_flush);
  assign w_illegal = r_op[2];
  assign w_a_row   = r_a[r_row*RW +: RW];

  mx_row_mac u_row_mac (
    .i_a_row (w_a_row),
    .i_b     (r_b),
    .o_row_c (w_mac_row)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // Next state and control strobes; flush beats both start and completion.
  always_comb begin
    w_nstate    = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_mmul_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mx_start && !mx_flush) begin
          w_accept = 1'b1;
          w_nstate = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mx_flush) begin
          w_nstate = ST_IDLE;
        end else if (r_op == MX_MMUL && r_row != 2'(DIM-1)) begin
          w_mmul_step = 1'b1;
        end else begin
          w_complete = 1'b1;
          w_nstate   = ST_IDLE;
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  // Full result for the latched op; multiply appends the last row live.
  always_comb begin
    w_result = '0;
    case (r_op)
      MX_MADD: begin
        for (int i = 0; i < DIM*DIM; i++) begin
          w_result[i*EW +: EW] = mx_narrow(mx_sext(r_a[i*EW +: EW]) + mx_sext(r_b[i*EW +: EW]));
        end
      end
      MX_MSUB: begin
        for (int i = 0; i < DIM*DIM; i++) begin
          w_result[i*EW +: EW] = mx_narrow(mx_sext(r_a[i*EW +: EW]) - mx_sext(r_b[i*EW +: EW]));
        end
      end
      MX_MMUL: begin
        w_result = {w_mac_row, r_buf};
      end
      MX_MTRANS: begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) begin
            w_result[(r*DIM + c)*EW +: EW] = r_a[(c*DIM + r)*EW +: EW];
          end
        end
      end
      default: w_result = '0;
    endcase
  end

  // Operand latch, row buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_row       <= '0;
      r_buf       <= '0;
      ex_matrix_o <= '0;
      mx_done     <= 1'b0;
      mx_busy     <= 1'b0;
      mx_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= mx_a;
        r_b   <= mx_b;
        r_op  <= mx_func3;
        r_row <= '0;
      end else if (w_mmul_step) begin
        case (r_row)
          2'd0:    r_buf[0    +: RW] <= w_mac_row;
          2'd1:    r_buf[RW   +: RW] <= w_mac_row;
          default: r_buf[2*RW +: RW] <= w_mac_row;
        endcase
        r_row <= r_row + 2'd1;
      end
      if (w_complete) begin
        ex_matrix_o <= w_result;
      end
      mx_done <= w_complete;
      mx_err  <= w_complete & w_illegal;
      mx_busy <= (w_nstate == ST_BUSY);
    end
  end

endmodule

// File: tb/tb_ex_matrix_unit.sv
// Directed bench for ex_matrix_unit: vector table plus flush/reset/overlap sequences.
module tb_ex_matrix_unit;
  import matrix_pkg::*;

  logic         clk;
  logic         rst;
  logic         mx_start;
  logic [2:0]   mx_func3;
  logic [127:0] mx_a;
  logic [127:0] mx_b;
  logic         mx_flush;
  logic [127:0] ex_matrix_o;
  logic         mx_done;
  logic         mx_busy;
  logic         mx_err;
  logic         mx_stall;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] ALL7F = {16{8'h7F}};
  localparam logic [127:0] ALL01 = {16{8'h01}};
  localparam logic [127:0] ALL80 = {16{8'h80}};
  localparam logic [127:0] ALLFF = {16{8'hFF}};
  localparam logic [127:0] ALLFC = {16{8'hFC}};
  localparam logic [127:0] ALL10 = {16{8'h10}};
  localparam logic [127:0] SEQ   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] SEQT  = 128'h0F0B0703_0E0A0602_0D090501_0C080400;
  localparam logic [127:0] SEQ10 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] SEQX2 = 128'h1E1C1A18_16141210_0E0C0A08_06040200;
  localparam logic [127:0] A_ID  = 128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] A_2I  = 128'h02000000_00020000_00000200_00000002;
  localparam logic [127:0] BR    = 128'hDEADBEEF_01234567_89ABCDEF_7F80FF00;
`ifdef MATRIX_SAT_EN
  localparam logic [127:0] E_MADD_OVF = ALL7F;
  localparam logic [127:0] E_MMUL_OVF = ALL7F;
  localparam logic [127:0] E_MSUB_OVF = ALL80;
`else
  localparam logic [127:0] E_MADD_OVF = ALL80;
  localparam logic [127:0] E_MMUL_OVF = {16{8'h04}};
  localparam logic [127:0] E_MSUB_OVF = ALL7F;
`endif

  typedef struct {
    logic [2:0]   f;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp;
    int           lat;
    logic         err;
    string        name;
  } vec_t;

  vec_t vecs [11];

  ex_matrix_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mx_start    (mx_start),
    .mx_func3    (mx_func3),
    .mx_a        (mx_a),
    .mx_b        (mx_b),
    .mx_flush    (mx_flush),
    .ex_matrix_o (ex_matrix_o),
    .mx_done     (mx_done),
    .mx_busy     (mx_busy),
    .mx_err      (mx_err),
    .mx_stall    (mx_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present a start for one cycle; returns just after the accepting edge.
  task automatic launch(input logic [2:0] f, input logic [127:0] a, input logic [127:0] b,
                        input string nm);
    @(negedge clk);
    mx_start = 1'b1;
    mx_func3 = f;
    mx_a     = a;
    mx_b     = b;
    #1;
    chk({nm, "_stall"}, 128'(mx_stall), 128'd1);
    @(posedge clk);
    #1;
    mx_start = 1'b0;
    chk({nm, "_busy"}, 128'(mx_busy), 128'd1);
  endtask

  // Wait for done, counting edges since the accept edge (bounded).
  task automatic wait_done(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (!mx_done && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_op(input vec_t v);
    int cyc;
    launch(v.f, v.a, v.b, v.name);
    wait_done(0, cyc);
    chk({v.name, "_lat"},    128'(cyc),     128'(v.lat));
    chk({v.name, "_res"},    ex_matrix_o,   v.exp);
    chk({v.name, "_err"},    128'(mx_err),  128'(v.err));
    chk({v.name, "_idle"},   128'(mx_busy), 128'd0);
  endtask

  initial begin
    int cyc;
    int ndone;

    vecs[0]  = '{MX_MADD,   ALL7F, ALL01, E_MADD_OVF, 1, 1'b0, "madd_ovf"};
    vecs[1]  = '{MX_MMUL,   ALL7F, ALL7F, E_MMUL_OVF, 4, 1'b0, "mmul_ovf"};
    vecs[2]  = '{MX_MMUL,   A_ID,  BR,    BR,         4, 1'b0, "mmul_ident"};
    vecs[3]  = '{MX_MTRANS, SEQ,   BR,    SEQT,       1, 1'b0, "mtrans"};
    vecs[4]  = '{3'b111,    SEQ,   SEQ,   '0,         1, 1'b1, "illegal7"};
    vecs[5]  = '{MX_MADD,   SEQ,   ALL10, SEQ10,      1, 1'b0, "madd_basic"};
    vecs[6]  = '{MX_MSUB,   SEQ,   SEQ,   '0,         1, 1'b0, "msub_self"};
    vecs[7]  = '{MX_MSUB,   ALL80, ALL01, E_MSUB_OVF, 1, 1'b0, "msub_ovf"};
    vecs[8]  = '{MX_MMUL,   A_2I,  SEQ,   SEQX2,      4, 1'b0, "mmul_scale"};
    vecs[9]  = '{3'b100,    SEQ,   SEQ,   '0,         1, 1'b1, "illegal4"};
    vecs[10] = '{MX_MMUL,   ALLFF, ALL01, ALLFC,      4, 1'b0, "mmul_neg"};

    rst      = 1'b1;
    mx_start = 1'b0;
    mx_func3 = '0;
    mx_a     = '0;
    mx_b     = '0;
    mx_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", ex_matrix_o,       '0);
    chk("rst_done",   128'(mx_done),     128'd0);
    chk("rst_busy",   128'(mx_busy),     128'd0);
    chk("rst_err",    128'(mx_err),      128'd0);
    chk("rst_stall",  128'(mx_stall),    128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each op launched in the previous op's done cycle.
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i]);
    end

    // Start during multiply is ignored and not queued.
    launch(MX_MMUL, A_ID, BR, "ovl");
    @(posedge clk);
    #1;
    @(negedge clk);
    mx_start = 1'b1;
    mx_func3 = MX_MADD;
    mx_a     = ALL7F;
    mx_b     = ALL01;
    #1;
    chk("ovl_stall_busy", 128'(mx_stall), 128'd1);
    @(posedge clk);
    #1;
    mx_start = 1'b0;
    wait_done(2, cyc);
    chk("ovl_lat", 128'(cyc),   128'd4);
    chk("ovl_res", ex_matrix_o, BR);
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (mx_done) ndone++;
    end
    chk("ovl_extra_done", 128'(ndone),   128'd0);
    chk("ovl_idle",       128'(mx_busy), 128'd0);

    // Flush (with a simultaneous start) mid-multiply.
    launch(MX_MMUL, ALL7F, ALL7F, "fl");
    @(posedge clk);
    #1;
    @(negedge clk);
    mx_flush = 1'b1;
    mx_start = 1'b1;
    mx_func3 = MX_MADD;
    @(posedge clk);
    #1;
    mx_flush = 1'b0;
    mx_start = 1'b0;
    chk("fl_busy", 128'(mx_busy), 128'd0);
    chk("fl_done", 128'(mx_done), 128'd0);
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (mx_done) ndone++;
    end
    chk("fl_no_done", 128'(ndone),   128'd0);
    chk("fl_hold",    ex_matrix_o,   BR);
    chk("fl_idle",    128'(mx_busy), 128'd0);

    // Flush and start together in idle: start dropped.
    @(negedge clk);
    mx_start = 1'b1;
    mx_flush = 1'b1;
    mx_func3 = MX_MSUB;
    #1;
    chk("idlefl_stall", 128'(mx_stall), 128'd0);
    @(posedge clk);
    #1;
    mx_start = 1'b0;
    mx_flush = 1'b0;
    chk("idlefl_busy", 128'(mx_busy), 128'd0);
    @(posedge clk);
    #1;
    chk("idlefl_done", 128'(mx_done), 128'd0);
    chk("idlefl_hold", ex_matrix_o,   BR);

    do_op(vecs[5]);

    // Reset mid-multiply clears every output.
    launch(MX_MMUL, A_2I, SEQ, "rmid");
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_result", ex_matrix_o,    '0);
    chk("rmid_done",   128'(mx_done),  128'd0);
    chk("rmid_busy",   128'(mx_busy),  128'd0);
    chk("rmid_err",    128'(mx_err),   128'd0);
    chk("rmid_stall",  128'(mx_stall), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(vecs[8]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
